// File: rtl/mem_req_scheduler.sv
// Row-aware FR-FCFS request scheduler: age-ordered request buffer, per-bank open-row
// tracking, starvation-bounded row-hit bypass, and page hit/miss statistics.
module mem_req_scheduler #(
  parameter int DEPTH      = 8,
  parameter int COL_BITS   = 10,
  parameter int BANK_BITS  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic                       req_we,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [31:0]                issue_addr,
  output logic                       issue_we,
  output logic                       issue_hit,
  output logic [31:0]                page_hit_counter,
  output logic [31:0]                page_miss_counter,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int NB       = 1 << BANK_BITS;
  localparam int ROW_BITS = 32 - COL_BITS - BANK_BITS;
  localparam int IW       = $clog2(DEPTH);
  localparam int OW       = $clog2(DEPTH+1);
  localparam int SW       = $clog2(STARVE_MAX+1);

  logic [DEPTH-1:0][31:0]       addr_q, addr_d;
  logic [DEPTH-1:0]             we_q, we_d;
  logic [OW-1:0]                occ_q, occ_d;
  logic [NB-1:0]                open_q;
  logic [NB-1:0][ROW_BITS-1:0]  row_q;
  logic [SW-1:0]                starve_q, starve_d;
  logic                         iv_q, iwe_q, ihit_q;
  logic [31:0]                  iaddr_q, hit_cnt_q, miss_cnt_q;

  logic [DEPTH-1:0]             hit_vec;
  logic [BANK_BITS-1:0]         bk;
  logic [IW-1:0]                sel_idx;
  logic                         sel_hit, sel_fire, enq;
  logic [31:0]                  sel_addr;
  logic                         sel_we;
  logic [BANK_BITS-1:0]         sel_bank;
  logic [ROW_BITS-1:0]          sel_row;
  logic [OW-1:0]                wr_idx;

  assign req_ready = (occ_q < OW'(DEPTH));
  assign enq       = req_valid && req_ready;
  assign sel_fire  = (occ_q != '0) && (!iv_q || issue_ready);

  // Slots past occupancy hold stale data; mask them out of the hit search.
  always_comb begin
    hit_vec = '0;
    bk      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bk         = addr_q[i][COL_BITS +: BANK_BITS];
      hit_vec[i] = (OW'(i) < occ_q) && open_q[bk] &&
                   (row_q[bk] == addr_q[i][COL_BITS+BANK_BITS +: ROW_BITS]);
    end
  end

  // Descending scan leaves the lowest-index hit; a starved head falls through to entry 0.
  always_comb begin
    sel_idx = '0;
    sel_hit = hit_vec[0];
    if (starve_q != SW'(STARVE_MAX)) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (hit_vec[i]) begin
          sel_idx = IW'(i);
          sel_hit = 1'b1;
        end
      end
    end
  end

  assign sel_addr = addr_q[sel_idx];
  assign sel_we   = we_q[sel_idx];
  assign sel_bank = sel_addr[COL_BITS +: BANK_BITS];
  assign sel_row  = sel_addr[COL_BITS+BANK_BITS +: ROW_BITS];
  assign wr_idx   = occ_q - OW'(sel_fire);

  always_comb begin
    addr_d = addr_q;
    we_d   = we_q;
    if (sel_fire) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        if (IW'(i) >= sel_idx) begin
          addr_d[i] = addr_q[i+1];
          we_d[i]   = we_q[i+1];
        end
      end
    end
    if (enq) begin
      addr_d[IW'(wr_idx)] = req_addr;
      we_d[IW'(wr_idx)]   = req_we;
    end
    occ_d = occ_q + OW'(enq) - OW'(sel_fire);
  end

  always_comb begin
    starve_d = starve_q;
    if (occ_q == '0)
      starve_d = '0;
    else if (sel_fire) begin
      if (sel_idx == '0)
        starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))
        starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      we_q       <= '0;
      occ_q      <= '0;
      open_q     <= '0;
      row_q      <= '0;
      starve_q   <= '0;
      iv_q       <= 1'b0;
      iaddr_q    <= '0;
      iwe_q      <= 1'b0;
      ihit_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      addr_q   <= addr_d;
      we_q     <= we_d;
      occ_q    <= occ_d;
      starve_q <= starve_d;
      if (sel_fire) begin
        iv_q             <= 1'b1;
        iaddr_q          <= sel_addr;
        iwe_q            <= sel_we;
        ihit_q           <= sel_hit;
        open_q[sel_bank] <= 1'b1;
        row_q[sel_bank]  <= sel_row;
        if (sel_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
        else         miss_cnt_q <= miss_cnt_q + 32'd1;
      end else if (iv_q && issue_ready) begin
        iv_q <= 1'b0;
      end
    end
  end

  assign issue_valid       = iv_q;
  assign issue_addr        = iaddr_q;
  assign issue_we          = iwe_q;
  assign issue_hit         = ihit_q;
  assign page_hit_counter  = hit_cnt_q;
  assign page_miss_counter = miss_cnt_q;
  assign occupancy         = occ_q;
endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler with hand-computed expected values.
module tb_mem_req_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] issue_addr;
  logic        issue_we;
  logic        issue_hit;
  logic [31:0] page_hit_counter, page_miss_counter;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  mem_req_scheduler #(.DEPTH(8), .COL_BITS(10), .BANK_BITS(2), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
    .issue_we(issue_we), .issue_hit(issue_hit),
    .page_hit_counter(page_hit_counter), .page_miss_counter(page_miss_counter),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = w;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid   = 1'b0;
    issue_ready = 1'b0;
    reset       = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] a, input logic h);
    chk({tag, "_v"}, 32'(issue_valid), 32'd1);
    chk({tag, "_a"}, issue_addr, a);
    chk({tag, "_h"}, 32'(issue_hit), 32'(h));
  endtask

  logic [31:0] exp_a [7];
  logic        exp_h [7];

  initial begin
    // Reset values
    step();
    chk("rst_iv",   32'(issue_valid), 32'd0);
    chk("rst_ia",   issue_addr, 32'd0);
    chk("rst_occ",  32'(occupancy), 32'd0);
    chk("rst_rdy",  32'(req_ready), 32'd1);
    chk("rst_hit",  page_hit_counter, 32'd0);
    chk("rst_miss", page_miss_counter, 32'd0);
    reset = 1'b1;
    step();

    // Single request latency
    issue_ready = 1'b1;
    push(32'h0000_1000, 1'b1);
    chk("lat_iv0", 32'(issue_valid), 32'd0);
    chk("lat_occ", 32'(occupancy), 32'd1);
    step();
    expect_issue("lat", 32'h0000_1000, 1'b0);
    chk("lat_we",   32'(issue_we), 32'd1);
    chk("lat_miss", page_miss_counter, 32'd1);
    chk("lat_hit",  page_hit_counter, 32'd0);
    step();
    chk("lat_drain", 32'(issue_valid), 32'd0);
    chk("lat_nocnt", page_miss_counter, 32'd1);

    // FR-FCFS reorder: A, then C (row hit) ahead of B
    do_reset();
    push(32'h0000_1000, 1'b0);
    push(32'h0000_2000, 1'b0);
    expect_issue("frA", 32'h0000_1000, 1'b0);
    push(32'h0000_1004, 1'b0);
    chk("frA_hold", issue_addr, 32'h0000_1000);
    chk("fr_occ",   32'(occupancy), 32'd2);
    issue_ready = 1'b1;
    step();
    expect_issue("frC", 32'h0000_1004, 1'b1);
    step();
    expect_issue("frB", 32'h0000_2000, 1'b0);
    step();
    chk("fr_done", 32'(issue_valid), 32'd0);
    chk("fr_hit",  page_hit_counter, 32'd1);
    chk("fr_miss", page_miss_counter, 32'd2);

    // Starvation: four bypasses, then the head is forced
    do_reset();
    push(32'h0000_1000, 1'b0);
    push(32'h0000_2000, 1'b0);
    for (int i = 1; i <= 6; i++) push(32'h0000_1000 + 32'(i*4), 1'b0);
    chk("st_occ", 32'(occupancy), 32'd7);
    exp_a = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h2000, 32'h1014, 32'h1018};
    exp_h = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    issue_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("st%0d_a", i), issue_addr, exp_a[i]);
      chk($sformatf("st%0d_h", i), 32'(issue_hit), 32'(exp_h[i]));
    end
    chk("st_hit",  page_hit_counter, 32'd5);
    chk("st_miss", page_miss_counter, 32'd3);

    // Full buffer backpressure
    do_reset();
    for (int i = 0; i < 9; i++) push(32'h0000_3000 + 32'(i*4), 1'b0);
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_rdy", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_addr  = 32'hAAAA_0000;
    step();
    chk("full_hold", 32'(occupancy), 32'd8);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("full_free", 32'(occupancy), 32'd7);
    chk("full_rdy1", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("full_enq", 32'(occupancy), 32'd8);
    chk("full_iv",  32'(issue_valid), 32'd1);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    chk("ar_iv",   32'(issue_valid), 32'd0);
    chk("ar_ia",   issue_addr, 32'd0);
    chk("ar_occ",  32'(occupancy), 32'd0);
    chk("ar_rdy",  32'(req_ready), 32'd1);
    chk("ar_hit",  page_hit_counter, 32'd0);
    chk("ar_miss", page_miss_counter, 32'd0);
    step();
    reset = 1'b1;
    issue_ready = 1'b1;
    push(32'h0000_3000, 1'b0);
    step();
    expect_issue("ar_new", 32'h0000_3000, 1'b0);

    // Bank independence
    do_reset();
    issue_ready = 1'b1;
    push(32'h0000_1000, 1'b0);
    push(32'h0000_1400, 1'b0);
    expect_issue("bk0", 32'h0000_1000, 1'b0);
    push(32'h0000_1008, 1'b0);
    expect_issue("bk1", 32'h0000_1400, 1'b0);
    step();
    expect_issue("bk2", 32'h0000_1008, 1'b1);
    chk("bk_hit",  page_hit_counter, 32'd1);
    chk("bk_miss", page_miss_counter, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
